// File: rtl/bit_serializer.sv
// Parallel-to-serial driver: one WIDTH-bit word out on out_sig, optional even parity, idle gap.
// Latency: first bit on out_sig the cycle after the in_valid/in_ready handshake edge.
// Backpressure: in_ready is high only in IDLE; in_valid elsewhere is ignored.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int MSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_sig,
  output logic             out_active,
  output logic             out_last,
  output logic [CNT_W-1:0] words_sent
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    idx;
  logic [GW-1:0]    gap_cnt;
  logic             parity;

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] d);
    if (MSB_FIRST != 0) return d << 1;
    else                return d >> 1;
  endfunction

  function automatic logic head(input logic [WIDTH-1:0] d);
    if (MSB_FIRST != 0) return d[WIDTH-1];
    else                return d[0];
  endfunction

  // idx counts bits already placed on out_sig, so idx==WIDTH means the last data bit is showing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      parity     <= 1'b0;
      in_ready   <= 1'b1;
      out_sig    <= 1'b0;
      out_active <= 1'b0;
      out_last   <= 1'b0;
      words_sent <= '0;
    end else begin
      if (out_last) words_sent <= words_sent + 1'b1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg      <= shift_once(in_data);
            parity     <= ^in_data;
            idx        <= IW'(1);
            out_sig    <= head(in_data);
            out_active <= 1'b1;
            out_last   <= (WIDTH == 1) && (PARITY_EN == 0);
            in_ready   <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx == IW'(WIDTH)) begin
            if (PARITY_EN != 0) begin
              out_sig  <= parity;
              out_last <= 1'b1;
              state    <= PARITY;
            end else begin
              out_sig    <= 1'b0;
              out_active <= 1'b0;
              out_last   <= 1'b0;
              if (GAP_CYCLES > 0) begin
                gap_cnt <= GW'(1);
                state   <= GAP;
              end else begin
                in_ready <= 1'b1;
                state    <= IDLE;
              end
            end
          end else begin
            out_sig  <= head(shreg);
            shreg    <= shift_once(shreg);
            idx      <= idx + 1'b1;
            out_last <= (idx == IW'(WIDTH - 1)) && (PARITY_EN == 0);
          end
        end
        PARITY: begin
          out_sig    <= 1'b0;
          out_active <= 1'b0;
          out_last   <= 1'b0;
          if (GAP_CYCLES > 0) begin
            gap_cnt <= GW'(1);
            state   <= GAP;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES)) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: four parameterisations sharing clk/rst.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // u0: defaults
  logic v0 = 1'b0, r0, s0, a0, l0;
  logic [7:0] d0 = 8'h00;
  logic [15:0] w0;
  // u1: LSB first, parity
  logic v1 = 1'b0, r1, s1, a1, l1;
  logic [7:0] d1 = 8'h00;
  logic [15:0] w1;
  // u2: no gap
  logic v2 = 1'b0, r2, s2, a2, l2;
  logic [7:0] d2 = 8'h00;
  logic [15:0] w2;
  // u3: one-bit word, 4-bit counter
  logic v3 = 1'b0, r3, s3, a3, l3;
  logic [0:0] d3 = 1'b0;
  logic [3:0] w3;

  bit_serializer u0 (.clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
                     .out_sig(s0), .out_active(a0), .out_last(l0), .words_sent(w0));
  bit_serializer #(.MSB_FIRST(0), .PARITY_EN(1)) u1 (.clk(clk), .rst(rst), .in_valid(v1),
                     .in_ready(r1), .in_data(d1), .out_sig(s1), .out_active(a1),
                     .out_last(l1), .words_sent(w1));
  bit_serializer #(.GAP_CYCLES(0)) u2 (.clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
                     .in_data(d2), .out_sig(s2), .out_active(a2), .out_last(l2),
                     .words_sent(w2));
  bit_serializer #(.WIDTH(1), .CNT_W(4)) u3 (.clk(clk), .rst(rst), .in_valid(v3),
                     .in_ready(r3), .in_data(d3), .out_sig(s3), .out_active(a3),
                     .out_last(l3), .words_sent(w3));

  task automatic test_reset();
    v0 = 1'b1; d0 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL reset active c%0d: got %b want 0", i, a0); end
      n_cmp++; if (s0 !== 1'b0) begin n_fail++; $display("FAIL reset sig c%0d: got %b want 0", i, s0); end
    end
    n_cmp++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL reset ready: got %b want 1", r0); end
    n_cmp++; if (l0 !== 1'b0) begin n_fail++; $display("FAIL reset last: got %b want 0", l0); end
    n_cmp++; if (w0 !== 16'd0) begin n_fail++; $display("FAIL reset words: got %0d want 0", w0); end
    n_cmp++; if (r3 !== 1'b1) begin n_fail++; $display("FAIL reset ready u3: got %b want 1", r3); end
    // release with in_valid already high: handshake on the first edge after release
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL release active: got %b want 1", a0); end
    n_cmp++; if (s0 !== 1'b1) begin n_fail++; $display("FAIL release first bit: got %b want 1", s0); end
    n_cmp++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL release ready: got %b want 0", r0); end
    v0 = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL async reset active: got %b want 0", a0); end
    n_cmp++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL async reset ready: got %b want 1", r0); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_defaults();
    logic [7:0] eb;
    eb = 8'b10100101;
    @(negedge clk);
    n_cmp++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL defaults ready pre: got %b want 1", r0); end
    v0 = 1'b1; d0 = 8'hA5;
    @(negedge clk);
    v0 = 1'b0; d0 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (s0 !== eb[7-i]) begin n_fail++; $display("FAIL defaults bit%0d: got %b want %b", i, s0, eb[7-i]); end
      n_cmp++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL defaults active%0d: got %b want 1", i, a0); end
      n_cmp++; if (l0 !== (i == 7)) begin n_fail++; $display("FAIL defaults last%0d: got %b want %b", i, l0, (i == 7)); end
      n_cmp++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL defaults ready%0d: got %b want 0", i, r0); end
      @(negedge clk);
    end
    n_cmp++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL defaults gap active: got %b want 0", a0); end
    n_cmp++; if (s0 !== 1'b0) begin n_fail++; $display("FAIL defaults gap sig: got %b want 0", s0); end
    n_cmp++; if (r0 !== 1'b0) begin n_fail++; $display("FAIL defaults gap ready: got %b want 0", r0); end
    n_cmp++; if (w0 !== 16'd1) begin n_fail++; $display("FAIL defaults words: got %0d want 1", w0); end
    @(negedge clk);
    n_cmp++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL defaults ready post: got %b want 1", r0); end
  endtask

  task automatic test_parity();
    logic [7:0] wd [2];
    logic       wp [2];
    wd[0] = 8'h07; wp[0] = 1'b1;
    wd[1] = 8'h03; wp[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (r1 !== 1'b1) begin n_fail++; $display("FAIL parity ready w%0d: got %b want 1", k, r1); end
      v1 = 1'b1; d1 = wd[k];
      @(negedge clk);
      v1 = 1'b0; d1 = 8'hFF;
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (s1 !== wd[k][i]) begin n_fail++; $display("FAIL parity w%0d bit%0d: got %b want %b", k, i, s1, wd[k][i]); end
        n_cmp++; if (l1 !== 1'b0) begin n_fail++; $display("FAIL parity w%0d last%0d: got %b want 0", k, i, l1); end
        @(negedge clk);
      end
      n_cmp++; if (s1 !== wp[k]) begin n_fail++; $display("FAIL parity w%0d pbit: got %b want %b", k, s1, wp[k]); end
      n_cmp++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL parity w%0d pactive: got %b want 1", k, a1); end
      n_cmp++; if (l1 !== 1'b1) begin n_fail++; $display("FAIL parity w%0d plast: got %b want 1", k, l1); end
      @(negedge clk);
      n_cmp++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL parity w%0d gap active: got %b want 0", k, a1); end
      n_cmp++; if (w1 !== 16'(k + 1)) begin n_fail++; $display("FAIL parity w%0d words: got %0d want %0d", k, w1, k + 1); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    n_cmp++; if (r2 !== 1'b1) begin n_fail++; $display("FAIL b2b ready pre: got %b want 1", r2); end
    v2 = 1'b1; d2 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if (s2 !== 1'b1) begin n_fail++; $display("FAIL b2b w0 bit%0d: got %b want 1", i, s2); end
      n_cmp++; if (r2 !== 1'b0) begin n_fail++; $display("FAIL b2b w0 ready%0d: got %b want 0", i, r2); end
      n_cmp++; if (l2 !== (i == 7)) begin n_fail++; $display("FAIL b2b w0 last%0d: got %b want %b", i, l2, (i == 7)); end
      if (i == 2) d2 = 8'h5A;
      if (i == 6) d2 = 8'h00;
    end
    @(negedge clk);
    n_cmp++; if (a2 !== 1'b0) begin n_fail++; $display("FAIL b2b idle active: got %b want 0", a2); end
    n_cmp++; if (r2 !== 1'b1) begin n_fail++; $display("FAIL b2b idle ready: got %b want 1", r2); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) v2 = 1'b0;
      n_cmp++; if (s2 !== 1'b0) begin n_fail++; $display("FAIL b2b w1 bit%0d: got %b want 0", i, s2); end
      n_cmp++; if (a2 !== 1'b1) begin n_fail++; $display("FAIL b2b w1 active%0d: got %b want 1", i, a2); end
      n_cmp++; if (l2 !== (i == 7)) begin n_fail++; $display("FAIL b2b w1 last%0d: got %b want %b", i, l2, (i == 7)); end
    end
    @(negedge clk);
    n_cmp++; if (w2 !== 16'd2) begin n_fail++; $display("FAIL b2b words: got %0d want 2", w2); end
    n_cmp++; if (r2 !== 1'b1) begin n_fail++; $display("FAIL b2b ready post: got %b want 1", r2); end
  endtask

  task automatic test_width1();
    logic eb;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      n_cmp++; if (r3 !== 1'b1) begin n_fail++; $display("FAIL w1 ready w%0d: got %b want 1", k, r3); end
      eb = (k % 2 == 1);
      v3 = 1'b1; d3 = eb;
      @(negedge clk);
      v3 = 1'b0; d3 = ~eb;
      n_cmp++; if (s3 !== eb) begin n_fail++; $display("FAIL w1 bit w%0d: got %b want %b", k, s3, eb); end
      n_cmp++; if (l3 !== 1'b1) begin n_fail++; $display("FAIL w1 last w%0d: got %b want 1", k, l3); end
      n_cmp++; if (a3 !== 1'b1) begin n_fail++; $display("FAIL w1 active w%0d: got %b want 1", k, a3); end
      @(negedge clk);
      n_cmp++; if (l3 !== 1'b0) begin n_fail++; $display("FAIL w1 gap last w%0d: got %b want 0", k, l3); end
      if (k == 14) begin n_cmp++; if (w3 !== 4'd15) begin n_fail++; $display("FAIL w1 words15: got %0d want 15", w3); end end
      if (k == 15) begin n_cmp++; if (w3 !== 4'd0) begin n_fail++; $display("FAIL w1 words wrap: got %0d want 0", w3); end end
      if (k == 16) begin n_cmp++; if (w3 !== 4'd1) begin n_fail++; $display("FAIL w1 words17: got %0d want 1", w3); end end
    end
  endtask

  task automatic test_rst_mid_word();
    logic [7:0] eb;
    eb = 8'b11000011;
    @(negedge clk);
    v0 = 1'b1; d0 = 8'hC3;
    @(negedge clk);
    v0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (s0 !== eb[7-i]) begin n_fail++; $display("FAIL midrst bit%0d: got %b want %b", i, s0, eb[7-i]); end
      if (i < 2) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL midrst active: got %b want 0", a0); end
    n_cmp++; if (s0 !== 1'b0) begin n_fail++; $display("FAIL midrst sig: got %b want 0", s0); end
    n_cmp++; if (r0 !== 1'b1) begin n_fail++; $display("FAIL midrst ready: got %b want 1", r0); end
    n_cmp++; if (w0 !== 16'd0) begin n_fail++; $display("FAIL midrst words: got %0d want 0", w0); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (w0 !== 16'd0) begin n_fail++; $display("FAIL midrst words post: got %0d want 0", w0); end
    n_cmp++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL midrst active post: got %b want 0", a0); end
    eb = 8'b10000001;
    v0 = 1'b1; d0 = 8'h81;
    @(negedge clk);
    v0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (s0 !== eb[7-i]) begin n_fail++; $display("FAIL midrst 81 bit%0d: got %b want %b", i, s0, eb[7-i]); end
      n_cmp++; if (l0 !== (i == 7)) begin n_fail++; $display("FAIL midrst 81 last%0d: got %b want %b", i, l0, (i == 7)); end
      @(negedge clk);
    end
    n_cmp++; if (w0 !== 16'd1) begin n_fail++; $display("FAIL midrst 81 words: got %0d want 1", w0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_defaults();
    test_parity();
    test_back_to_back();
    test_width1();
    test_rst_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
